// File: rtl/sym_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sym_fir_pkg
// Brief    : Shared types, default coefficients and sizing helpers for the
//            symmetric bit-stream FIR family.
// Revision : 1.0
// ============================================================================
package sym_fir_pkg;

    localparam int COEF_W_DEFAULT    = 16;
    localparam int NUM_DEFAULT_COEFS = 16;

    typedef logic signed [COEF_W_DEFAULT-1:0] coef_t;

    // h[0] is the outermost tap pair, h[NUM_DEFAULT_COEFS-1] the centre pair.
    localparam coef_t DEFAULT_COEFS [NUM_DEFAULT_COEFS] = '{
        16'sd1,   -16'sd3,  -16'sd7,  -16'sd5,
        16'sd6,    16'sd20,  16'sd31,  16'sd22,
        -16'sd15, -16'sd64, -16'sd98, -16'sd71,
        16'sd60,   16'sd280, 16'sd520, 16'sd700
    };

    function automatic int calc_out_w(input int num_taps, input int coef_w);
        return coef_w + 1 + $clog2(num_taps / 2);
    endfunction

    function automatic int calc_lat(input int num_taps);
        return 2 + $clog2(num_taps / 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sym_fir_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : sym_fir_adder_tree
// Brief    : Registered binary reduction of N_IN signed words; each level adds
//            pairs and grows the word by one bit, so the result is exact.
// Revision : 1.0
// ============================================================================
module sym_fir_adder_tree #(
    parameter  int N_IN   = 16,
    parameter  int IN_W   = 17,
    localparam int LEVELS = $clog2(N_IN),
    localparam int OUT_W  = IN_W + LEVELS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LEVELS-1:0]       i_en,
    input  logic [N_IN*IN_W-1:0]    i_data,
    output logic signed [OUT_W-1:0] o_sum
);

    generate
        for (genvar l = 0; l < LEVELS; l++) begin : g_level
            localparam int C_N = N_IN >> (l + 1);
            localparam int C_W = IN_W + l + 1;

            logic [2*C_N*(C_W-1)-1:0] w_in;
            logic [C_N*C_W-1:0]       r_sum;

            if (l == 0) begin : g_leaf
                assign w_in = i_data;
            end else begin : g_inner
                assign w_in = g_level[l-1].r_sum;
            end

            // Operands are sign-extended by one bit before the add.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                end else if (i_en[l]) begin
                    for (int i = 0; i < C_N; i++) begin
                        r_sum[i*C_W +: C_W] <=
                              {w_in[(2*i+1)*(C_W-1)-1], w_in[2*i*(C_W-1) +: C_W-1]}
                            + {w_in[(2*i+2)*(C_W-1)-1], w_in[(2*i+1)*(C_W-1) +: C_W-1]};
                    end
                end
            end
        end
    endgenerate

    assign o_sum = g_level[LEVELS-1].r_sum;

endmodule
`default_nettype wire

// File: rtl/sym_fir_bitstream.sv
`default_nettype none
// ============================================================================
// Module   : sym_fir_bitstream
// Brief    : Symmetric even-length FIR over a serial bit stream (1 -> +1,
//            0 -> -1), multiplier-free, one sample per clock.
// Revision : 1.0
// ============================================================================
module sym_fir_bitstream
    import sym_fir_pkg::*;
#(
    parameter  int NUM_TAPS = 32,
    parameter  int COEF_W   = 16,
    localparam int HALF     = NUM_TAPS / 2,
    localparam int ADDR_W   = $clog2(HALF),
    localparam int LEVELS   = $clog2(HALF),
    localparam int TERM_W   = COEF_W + 1,
    localparam int OUT_W    = calc_out_w(NUM_TAPS, COEF_W),
    localparam int LAT      = calc_lat(NUM_TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     bit_in,
    input  logic                     coef_we,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  y_data
);

    generate
        if ((NUM_TAPS % 2) != 0 || HALF < 2 || (HALF & (HALF - 1)) != 0) begin : g_bad_num_taps
            $error("sym_fir_bitstream: NUM_TAPS must be even with NUM_TAPS/2 a power of two >= 2");
        end
    endgenerate

    logic [NUM_TAPS-1:0]      r_x;
    logic signed [COEF_W-1:0] r_h [HALF];
    logic [HALF*TERM_W-1:0]   r_p;
    logic [LAT-1:0]           r_v;
    logic signed [OUT_W-1:0]  w_tree_sum;

    // A clear coinciding with a valid sample leaves only that sample in x[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
        end else if (clear) begin
            r_x <= {{(NUM_TAPS-1){1'b0}}, in_valid & bit_in};
        end else if (in_valid) begin
            r_x <= {r_x[NUM_TAPS-2:0], bit_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HALF; k++) begin
                r_h[k] <= COEF_W'(DEFAULT_COEFS[k % NUM_DEFAULT_COEFS]);
            end
        end else if (coef_we) begin
            r_h[coef_addr] <= coef_data;
        end
    end

    // Pair term: matching bits give +/-2h, differing bits cancel to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (r_v[0]) begin
            for (int k = 0; k < HALF; k++) begin
                if (r_x[k] && r_x[NUM_TAPS-1-k]) begin
                    r_p[k*TERM_W +: TERM_W] <= {r_h[k], 1'b0};
                end else if (!r_x[k] && !r_x[NUM_TAPS-1-k]) begin
                    r_p[k*TERM_W +: TERM_W] <= -{r_h[k], 1'b0};
                end else begin
                    r_p[k*TERM_W +: TERM_W] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else if (clear) begin
            r_v <= {{(LAT-1){1'b0}}, in_valid};
        end else begin
            r_v <= {r_v[LAT-2:0], in_valid};
        end
    end

    // Each tree level only advances with a valid sample, so y_data holds across gaps.
    sym_fir_adder_tree #(
        .N_IN (HALF),
        .IN_W (TERM_W)
    ) u_adder_tree (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_v[LEVELS:1]),
        .i_data (r_p),
        .o_sum  (w_tree_sum)
    );

    assign y_data    = w_tree_sum;
    assign out_valid = r_v[LAT-1];

endmodule
`default_nettype wire
